// File: rtl/mem_issue_unit.sv
// In-order LSQ feeding a tagged dcache port whose responses may complete out of order.
// Optional feature MEM_ISSUE_MISALIGN_CHECK_EN traps size-misaligned ops instead of issuing them.
module mem_issue_unit #(
    parameter int LSQ_DEPTH    = 8,
    parameter int MAX_INFLIGHT = 4,
    parameter int TAG_W        = $clog2(MAX_INFLIGHT),
    parameter int IDX_W        = $clog2(LSQ_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             enq_valid_i,
    output logic             enq_ready_o,
    input  logic [63:0]      enq_addr_i,
    input  logic [63:0]      enq_data_i,
    input  logic             enq_is_store_i,
    input  logic [2:0]       enq_funct3_i,
    input  logic [4:0]       enq_rd_i,
    output logic [IDX_W-1:0] enq_idx_o,
    input  logic             kill_i,
    input  logic             flush_i,
    output logic             req_valid_o,
    input  logic             req_ready_i,
    output logic [63:0]      req_addr_o,
    output logic [63:0]      req_data_o,
    output logic             req_is_store_o,
    output logic [2:0]       req_funct3_o,
    output logic [TAG_W-1:0] req_tag_o,
    input  logic             rsp_valid_i,
    input  logic [TAG_W-1:0] rsp_tag_i,
    input  logic [63:0]      rsp_data_i,
    output logic             wb_valid_o,
    output logic [4:0]       wb_rd_o,
    output logic [63:0]      wb_data_o,
    output logic             wb_xcpt_o,
    output logic             busy_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_ST_WAIT = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    logic [63:0]          lsq_addr_q [LSQ_DEPTH];
    logic [63:0]          lsq_data_q [LSQ_DEPTH];
    logic [2:0]           lsq_f3_q   [LSQ_DEPTH];
    logic [4:0]           lsq_rd_q   [LSQ_DEPTH];
    logic [LSQ_DEPTH-1:0] lsq_st_q;

    logic [IDX_W:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]     state_q, state_d;

    logic [MAX_INFLIGHT-1:0] slot_busy_q, slot_busy_d;
    logic [MAX_INFLIGHT-1:0] slot_sq_q, slot_sq_d;
    logic [MAX_INFLIGHT-1:0] slot_st_q;
    logic [4:0]              slot_rd_q  [MAX_INFLIGHT];
    logic [2:0]              slot_f3_q  [MAX_INFLIGHT];
    logic [2:0]              slot_off_q [MAX_INFLIGHT];

    logic             kill_any, empty, full, any_busy, any_free;
    logic             head_st, head_mis, state_ok, store_ok;
    logic             can_issue, issue_fire, mis_pop, pop, push;
    logic             rsp_hit, rsp_wb;
    logic [IDX_W-1:0] head_idx, tail_idx;
    logic [TAG_W-1:0] free_tag;
    logic [63:0]      head_addr, load_data;
    logic [2:0]       head_f3;

    function automatic logic [63:0] fmt_load(input logic [63:0] d, input logic [2:0] f3,
                                             input logic [2:0] off);
        logic [63:0] raw;
        raw = d >> {off, 3'b000};
        case (f3)
            3'b000:  return {{56{raw[7]}}, raw[7:0]};
            3'b001:  return {{48{raw[15]}}, raw[15:0]};
            3'b010:  return {{32{raw[31]}}, raw[31:0]};
            3'b100:  return {56'd0, raw[7:0]};
            3'b101:  return {48'd0, raw[15:0]};
            3'b110:  return {32'd0, raw[31:0]};
            default: return raw;
        endcase
    endfunction

    assign kill_any  = kill_i | flush_i;
    assign head_idx  = head_q[IDX_W-1:0];
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign empty     = (head_q == tail_q);
    assign full      = (head_q[IDX_W] != tail_q[IDX_W]) &&
                       (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
    assign head_addr = lsq_addr_q[head_idx];
    assign head_f3   = lsq_f3_q[head_idx];
    assign head_st   = lsq_st_q[head_idx];
    assign any_busy  = |slot_busy_q;
    assign any_free  = ~&slot_busy_q;

    always_comb begin
        free_tag = '0;
        for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
            if (!slot_busy_q[i]) free_tag = TAG_W'(i);
        end
    end

    // Squashed requests must all return before anything new is sent after a kill.
    assign state_ok   = (state_q != S_DRAIN) | ~any_busy;
    assign store_ok   = ~head_st | ~any_busy;
    assign can_issue  = ~kill_any & ~empty & state_ok & any_free & store_ok & ~head_mis;
    assign issue_fire = can_issue & req_ready_i;
    assign pop        = issue_fire | mis_pop;
    assign push       = enq_valid_i & ~full & ~kill_any;

    assign req_valid_o    = can_issue;
    assign req_addr_o     = can_issue ? head_addr : '0;
    assign req_data_o     = can_issue ? lsq_data_q[head_idx] : '0;
    assign req_is_store_o = can_issue & head_st;
    assign req_funct3_o   = can_issue ? head_f3 : '0;
    assign req_tag_o      = can_issue ? free_tag : '0;
    assign enq_ready_o    = ~full;
    assign enq_idx_o      = tail_idx;
    assign busy_o         = ~empty | any_busy;

    assign rsp_hit   = rsp_valid_i & slot_busy_q[rsp_tag_i];
    assign rsp_wb    = rsp_hit & ~slot_st_q[rsp_tag_i] & ~slot_sq_q[rsp_tag_i] & ~kill_any;
    assign load_data = fmt_load(rsp_data_i, slot_f3_q[rsp_tag_i], slot_off_q[rsp_tag_i]);

`ifdef MEM_ISSUE_MISALIGN_CHECK_EN
    logic        xcpt_q;
    logic [4:0]  xcpt_rd_q;
    logic [63:0] xcpt_addr_q;

    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            2'b11:   return |off;
            default: return 1'b0;
        endcase
    endfunction

    // One trap can be pending; a second misaligned head waits until it is reported.
    assign head_mis = ~empty & misaligned(head_f3, head_addr[2:0]);
    assign mis_pop  = ~kill_any & head_mis & state_ok & ~xcpt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)       xcpt_q <= 1'b0;
        else if (kill_any) xcpt_q <= 1'b0;
        else if (mis_pop)  xcpt_q <= 1'b1;
        else if (!rsp_wb)  xcpt_q <= 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (mis_pop) begin
            xcpt_rd_q   <= lsq_rd_q[head_idx];
            xcpt_addr_q <= head_addr;
        end
    end
`else
    assign head_mis = 1'b0;
    assign mis_pop  = 1'b0;
`endif

    // A load response takes the writeback port ahead of a pending trap.
    always_comb begin
        wb_valid_o = 1'b0;
        wb_rd_o    = '0;
        wb_data_o  = '0;
        wb_xcpt_o  = 1'b0;
        if (rsp_wb) begin
            wb_valid_o = 1'b1;
            wb_rd_o    = slot_rd_q[rsp_tag_i];
            wb_data_o  = load_data;
        end
`ifdef MEM_ISSUE_MISALIGN_CHECK_EN
        else if (xcpt_q && !kill_any) begin
            wb_valid_o = 1'b1;
            wb_xcpt_o  = 1'b1;
            wb_rd_o    = xcpt_rd_q;
            wb_data_o  = xcpt_addr_q;
        end
`endif
    end

    always_comb begin
        head_d = head_q + {{IDX_W{1'b0}}, pop};
        tail_d = tail_q + {{IDX_W{1'b0}}, push};
        if (kill_any) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    always_comb begin
        slot_busy_d = slot_busy_q;
        slot_sq_d   = slot_sq_q;
        if (rsp_hit) slot_busy_d[rsp_tag_i] = 1'b0;
        if (kill_any) slot_sq_d = slot_sq_q | slot_busy_q;
        if (issue_fire) begin
            slot_busy_d[free_tag] = 1'b1;
            slot_sq_d[free_tag]   = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (kill_any) begin
            state_d = any_busy ? S_DRAIN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (!empty) state_d = S_ISSUE;
                S_ISSUE: begin
                    if (empty) state_d = S_IDLE;
                    else if (head_st && any_busy && !head_mis) state_d = S_ST_WAIT;
                end
                S_ST_WAIT: if (!any_busy) state_d = S_ISSUE;
                default:   if (!any_busy) state_d = empty ? S_IDLE : S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            slot_busy_q <= '0;
            slot_sq_q   <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            slot_busy_q <= slot_busy_d;
            slot_sq_q   <= slot_sq_d;
        end
    end

    // Payload storage is only meaningful under the valid/busy bits, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            lsq_addr_q[tail_idx] <= enq_addr_i;
            lsq_data_q[tail_idx] <= enq_data_i;
            lsq_f3_q[tail_idx]   <= enq_funct3_i;
            lsq_rd_q[tail_idx]   <= enq_rd_i;
            lsq_st_q[tail_idx]   <= enq_is_store_i;
        end
        if (issue_fire) begin
            slot_rd_q[free_tag]  <= lsq_rd_q[head_idx];
            slot_f3_q[free_tag]  <= head_f3;
            slot_off_q[free_tag] <= head_addr[2:0];
            slot_st_q[free_tag]  <= head_st;
        end
    end

`ifdef ASSERTIONS
    rsp_to_busy_slot: assert property (@(posedge clk_i) disable iff (!rstn_i)
        rsp_valid_i |-> slot_busy_q[rsp_tag_i]);
`endif

endmodule

// File: tb/tb_mem_issue_unit.sv
// Randomized bench for mem_issue_unit with a queue/array reference model of the LSQ and slots.
module tb_mem_issue_unit;

    localparam int DEPTH = 8;
    localparam int MI    = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        enq_valid_i, enq_ready_o, enq_is_store_i;
    logic [63:0] enq_addr_i, enq_data_i;
    logic [2:0]  enq_funct3_i;
    logic [4:0]  enq_rd_i;
    logic [2:0]  enq_idx_o;
    logic        kill_i, flush_i;
    logic        req_valid_o, req_ready_i, req_is_store_o;
    logic [63:0] req_addr_o, req_data_o;
    logic [2:0]  req_funct3_o;
    logic [1:0]  req_tag_o;
    logic        rsp_valid_i;
    logic [1:0]  rsp_tag_i;
    logic [63:0] rsp_data_i;
    logic        wb_valid_o, wb_xcpt_o, busy_o;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_data_o;

    mem_issue_unit #(.LSQ_DEPTH(DEPTH), .MAX_INFLIGHT(MI)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_addr_i(enq_addr_i),
        .enq_data_i(enq_data_i), .enq_is_store_i(enq_is_store_i), .enq_funct3_i(enq_funct3_i),
        .enq_rd_i(enq_rd_i), .enq_idx_o(enq_idx_o), .kill_i(kill_i), .flush_i(flush_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .req_data_o(req_data_o), .req_is_store_o(req_is_store_o), .req_funct3_o(req_funct3_o),
        .req_tag_o(req_tag_o), .rsp_valid_i(rsp_valid_i), .rsp_tag_i(rsp_tag_i),
        .rsp_data_i(rsp_data_i), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .wb_xcpt_o(wb_xcpt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_on = 1'b1;

    // stimulus for the next cycle
    bit          s_ev, s_st, s_rr, s_rv, s_kill, s_flush;
    logic [63:0] s_addr, s_data, s_rdata;
    logic [2:0]  s_f3;
    logic [4:0]  s_rd;
    logic [1:0]  s_rt;

    // reference model
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        bit          st;
        logic [2:0]  f3;
        logic [4:0]  rd;
    } op_t;
    op_t        m_q[$];
    bit         m_busy[MI];
    bit         m_sq[MI];
    bit         m_st[MI];
    logic [4:0] m_rd[MI];
    logic [2:0] m_f3[MI];
    logic [2:0] m_off[MI];
    int         m_tail;
    bit         m_drain;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_fmt(input logic [63:0] d, input logic [2:0] f3,
                                            input logic [2:0] off);
        int bits;
        logic [63:0] v, mask;
        v = d >> (int'(off) * 8);
        bits = 8 * (1 << f3[1:0]);
        if (bits == 64) return v;
        mask = (64'd1 << bits) - 64'd1;
        v = v & mask;
        if (!f3[2] && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic clr();
        s_ev = 0; s_st = 0; s_rr = 0; s_rv = 0; s_kill = 0; s_flush = 0;
        s_addr = '0; s_data = '0; s_rdata = '0; s_f3 = '0; s_rd = '0; s_rt = '0;
    endtask

    task automatic enq(input logic [63:0] a, input bit st, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [63:0] d);
        s_ev = 1; s_addr = a; s_st = st; s_f3 = f3; s_rd = rd; s_data = d;
    endtask

    task automatic drive();
        enq_valid_i = s_ev; enq_addr_i = s_addr; enq_data_i = s_data;
        enq_is_store_i = s_st; enq_funct3_i = s_f3; enq_rd_i = s_rd;
        req_ready_i = s_rr; rsp_valid_i = s_rv; rsp_tag_i = s_rt; rsp_data_i = s_rdata;
        kill_i = s_kill; flush_i = s_flush;
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < MI; i++) begin
            m_busy[i] = 0; m_sq[i] = 0;
        end
        m_tail = 0;
        m_drain = 0;
    endtask

    // One clock: drive at negedge, compare mid-cycle, advance the model to the next edge.
    task automatic cycle();
        bit kill, e_rdy, e_rv, hit, e_wb;
        int nb, ft;
        op_t o;
        @(negedge clk_i);
        drive();
        #1;
        if (model_on) begin
            kill = s_kill | s_flush;
            nb = 0;
            ft = 0;
            for (int i = 0; i < MI; i++) if (m_busy[i]) nb++;
            for (int i = MI - 1; i >= 0; i--) if (!m_busy[i]) ft = i;
            e_rdy = (m_q.size() < DEPTH);
            e_rv  = !kill && m_q.size() > 0 && !(m_drain && nb > 0) && nb < MI &&
                    (!m_q[0].st || nb == 0);
            hit   = s_rv && m_busy[s_rt];
            e_wb  = hit && !m_st[s_rt] && !m_sq[s_rt] && !kill;

            check("enq_ready", enq_ready_o, e_rdy);
            check("enq_idx", enq_idx_o, m_tail);
            check("busy", busy_o, (m_q.size() > 0 || nb > 0));
            check("req_valid", req_valid_o, e_rv);
            if (e_rv) begin
                check("req_tag", req_tag_o, ft);
                check("req_addr", req_addr_o, m_q[0].addr);
                check("req_is_store", req_is_store_o, m_q[0].st);
                check("req_funct3", req_funct3_o, m_q[0].f3);
                if (m_q[0].st) check("req_data", req_data_o, m_q[0].data);
            end
            check("wb_valid", wb_valid_o, e_wb);
            check("wb_xcpt", wb_xcpt_o, 0);
            if (e_wb) begin
                check("wb_rd", wb_rd_o, m_rd[s_rt]);
                check("wb_data", wb_data_o, exp_fmt(s_rdata, m_f3[s_rt], m_off[s_rt]));
            end

            if (kill) begin
                for (int i = 0; i < MI; i++) if (m_busy[i]) m_sq[i] = 1;
                m_drain = (nb > 0);
                m_q.delete();
                m_tail = 0;
            end
            if (hit) m_busy[s_rt] = 0;
            if (!kill) begin
                if (m_drain && nb == 0) m_drain = 0;
                if (e_rv && s_rr) begin
                    o = m_q.pop_front();
                    m_busy[ft] = 1; m_sq[ft] = 0; m_st[ft] = o.st;
                    m_rd[ft] = o.rd; m_f3[ft] = o.f3; m_off[ft] = o.addr[2:0];
                end
                if (s_ev && e_rdy) begin
                    o.addr = s_addr; o.data = s_data; o.st = s_st; o.f3 = s_f3; o.rd = s_rd;
                    m_q.push_back(o);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
    endtask

    task automatic do_reset();
        clr();
        @(negedge clk_i);
        drive();
        rstn_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_enq_ready", enq_ready_o, 1);
        check("rst_req_valid", req_valid_o, 0);
        check("rst_req_tag", req_tag_o, 0);
        check("rst_req_addr", req_addr_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_wb_data", wb_data_o, 0);
        check("rst_wb_xcpt", wb_xcpt_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_enq_idx", enq_idx_o, 0);
        model_reset();
        rstn_i = 1'b1;
    endtask

    // Enqueue one load, issue it, respond on tag 0 and compare the formatted result.
    task automatic one_load(input logic [63:0] a, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [63:0] d, input logic [63:0] exp_data, input string nm);
        clr(); enq(a, 0, f3, rd, 0); s_rr = 1; cycle();
        clr(); s_rr = 1; cycle();
        check({nm, "_req_valid"}, req_valid_o, 1);
        check({nm, "_req_tag"}, req_tag_o, 0);
        clr(); s_rv = 1; s_rt = 0; s_rdata = d; cycle();
        check({nm, "_wb_valid"}, wb_valid_o, 1);
        check({nm, "_wb_rd"}, wb_rd_o, rd);
        check({nm, "_wb_data"}, wb_data_o, exp_data);
    endtask

    task automatic rsp(input logic [1:0] t, input logic [63:0] d, input bit rr);
        clr(); s_rv = 1; s_rt = t; s_rdata = d; s_rr = rr; cycle();
    endtask

    task automatic rand_cycle();
        int bl[$];
        clr();
        if ($urandom_range(1, 0) == 1) begin
            s_ev = 1;
            s_st = ($urandom_range(3, 0) == 0);
            s_f3 = s_st ? 3'($urandom_range(3, 0)) : 3'($urandom_range(6, 0));
            s_addr = {$urandom, $urandom};
`ifdef MEM_ISSUE_MISALIGN_CHECK_EN
            s_addr = s_addr & ~((64'd1 << s_f3[1:0]) - 64'd1);
`endif
            s_data = {$urandom, $urandom};
            s_rd = 5'($urandom_range(31, 0));
        end
        s_rr = ($urandom_range(2, 0) != 0);
        for (int i = 0; i < MI; i++) if (m_busy[i]) bl.push_back(i);
        if (bl.size() > 0 && $urandom_range(1, 0) == 1) begin
            s_rv = 1;
            s_rt = 2'(bl[$urandom_range(bl.size() - 1, 0)]);
            s_rdata = {$urandom, $urandom};
        end
        s_kill  = ($urandom_range(63, 0) == 0);
        s_flush = ($urandom_range(63, 0) == 0);
        cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b1;
        do_reset();

        one_load(64'h1000, 3'b011, 5, 64'h1122334455667788, 64'h1122334455667788, "ld");
        one_load(64'h1007, 3'b000, 3, 64'h80AB_CDEF_0123_4567, 64'hFFFF_FFFF_FFFF_FF80, "lb");
        one_load(64'h1007, 3'b100, 3, 64'h80AB_CDEF_0123_4567, 64'h0000_0000_0000_0080, "lbu");
        one_load(64'h1006, 3'b001, 4, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, "lh");
        one_load(64'h1004, 3'b110, 4, 64'h8001_0002_0000_0000, 64'h0000_0000_8001_0002, "lwu");

        // four in flight, fifth held, out-of-order responses
        for (int i = 0; i < 5; i++) begin
            clr(); enq(64'h2000 + 64'(8 * i), 0, 3'b011, 5'(10 + i), 0); s_rr = 1; cycle();
        end
        clr(); s_rr = 1; cycle();
        check("ooo_held", req_valid_o, 0);
        rsp(2, 64'hA2, 0);
        check("ooo_rd2", wb_rd_o, 12);
        rsp(0, 64'hA0, 1);
        check("ooo_rd0", wb_rd_o, 10);
        check("ooo_reissue_valid", req_valid_o, 1);
        check("ooo_reissue_tag", req_tag_o, 2);
        rsp(3, 64'hA3, 0);
        check("ooo_rd3", wb_rd_o, 13);
        rsp(1, 64'hA1, 0);
        check("ooo_rd1", wb_rd_o, 11);
        rsp(2, 64'hA4, 0);
        check("ooo_rd4", wb_rd_o, 14);

        // store waits for the in-flight load
        clr(); enq(64'h3000, 0, 3'b011, 6, 0); s_rr = 1; cycle();
        clr(); enq(64'h3008, 1, 3'b011, 0, 64'hDEAD_BEEF); s_rr = 1; cycle();
        clr(); s_rr = 1; cycle();
        check("st_wait0", req_valid_o, 0);
        clr(); s_rr = 1; cycle();
        check("st_wait1", req_valid_o, 0);
        rsp(0, 64'h55, 1);
        check("st_wait_rsp", req_valid_o, 0);
        clr(); s_rr = 1; cycle();
        check("st_issue", req_valid_o, 1);
        check("st_is_store", req_is_store_o, 1);
        check("st_data", req_data_o, 64'hDEAD_BEEF);
        rsp(0, 64'h77, 0);
        check("st_no_wb", wb_valid_o, 0);

        // response coinciding with flush is squashed
        clr(); enq(64'h3100, 0, 3'b011, 9, 0); s_rr = 1; cycle();
        clr(); s_rr = 1; cycle();
        clr(); s_rv = 1; s_rt = 0; s_rdata = 64'h99; s_flush = 1; cycle();
        check("flush_rsp_no_wb", wb_valid_o, 0);
        clr(); cycle();

        // fill, kill with two in flight, drain
        clr(); enq(64'h4000, 0, 3'b011, 1, 0); s_rr = 1; cycle();
        clr(); enq(64'h4008, 0, 3'b011, 2, 0); s_rr = 1; cycle();
        clr(); s_rr = 1; cycle();
        for (int i = 0; i < DEPTH; i++) begin
            clr(); enq(64'h5000 + 64'(8 * i), 0, 3'b011, 5'(16 + i), 0); cycle();
        end
        clr(); enq(64'h6000, 0, 3'b011, 30, 0); cycle();
        check("full_ready", enq_ready_o, 0);
        clr(); enq(64'h6008, 0, 3'b011, 31, 0); s_kill = 1; s_rr = 1; cycle();
        check("kill_req_valid", req_valid_o, 0);
        clr(); cycle();
        check("kill_ready", enq_ready_o, 1);
        check("kill_idx", enq_idx_o, 0);
        check("kill_busy", busy_o, 1);
        clr(); enq(64'h7000, 0, 3'b011, 7, 0); s_rr = 1; cycle();
        clr(); s_rr = 1; cycle();
        check("drain_hold", req_valid_o, 0);
        rsp(0, 64'h1, 1);
        check("drain_no_wb0", wb_valid_o, 0);
        rsp(1, 64'h2, 1);
        check("drain_no_wb1", wb_valid_o, 0);
        clr(); s_rr = 1; cycle();
        check("drain_exit_issue", req_valid_o, 1);
        rsp(0, 64'h3, 0);
        check("drain_new_wb", wb_valid_o, 1);
        clr(); cycle();
        check("drain_idle_busy", busy_o, 0);

`ifndef MEM_ISSUE_MISALIGN_CHECK_EN
        clr(); enq(64'h1002, 0, 3'b010, 7, 0); s_rr = 1; cycle();
        clr(); s_rr = 1; cycle();
        check("mis_issue_valid", req_valid_o, 1);
        check("mis_issue_addr", req_addr_o, 64'h1002);
        rsp(0, 64'h0000_0000_8765_4321, 0);
        check("mis_issue_xcpt", wb_xcpt_o, 0);
`endif

        for (int c = 0; c < 3000; c++) rand_cycle();
        for (int c = 0; c < 40; c++) begin
            clr(); s_rr = 1;
            for (int i = 0; i < MI; i++) if (m_busy[i]) begin s_rv = 1; s_rt = 2'(i); end
            cycle();
        end
        check("final_busy", busy_o, 0);

`ifdef MEM_ISSUE_MISALIGN_CHECK_EN
        do_reset();
        model_on = 1'b0;
        clr(); enq(64'h1002, 0, 3'b010, 7, 0); s_rr = 1; cycle();
        clr(); s_rr = 1; cycle();
        check("mis_no_req", req_valid_o, 0);
        clr(); cycle();
        check("mis_wb_valid", wb_valid_o, 1);
        check("mis_wb_xcpt", wb_xcpt_o, 1);
        check("mis_wb_rd", wb_rd_o, 7);
        check("mis_wb_data", wb_data_o, 64'h1002);
        clr(); cycle();
        check("mis_wb_once", wb_valid_o, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
